// File: rtl/pwm_tone_gen_if.sv
// rtl/pwm_tone_gen_if.sv - sequencer-to-tone-generator bundle
interface pwm_tone_gen_if #(
    parameter int CNT_W = 32
);
    logic             cnt_en;
    logic [CNT_W-1:0] counter_arr;
    logic [CNT_W-1:0] counter_ccr;
    logic             o_pwm;
    logic             period_tick;
    logic             active;

    // note source side: presents period/duty, observes the waveform
    modport master (
        output cnt_en,
        output counter_arr,
        output counter_ccr,
        input  o_pwm,
        input  period_tick,
        input  active
    );

    // tone generator side
    modport slave (
        input  cnt_en,
        input  counter_arr,
        input  counter_ccr,
        output o_pwm,
        output period_tick,
        output active
    );
endinterface

// File: rtl/pwm_tone_gen.sv
// rtl/pwm_tone_gen.sv - glitch-free square-wave PWM tone generator for the buzzer
module pwm_tone_gen #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    pwm_tone_gen_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] arr_sh;
    logic [CNT_W-1:0] ccr_sh;
    logic             pwm_q;
    logic             tick_q;
    logic             active_q;

    logic [CNT_W-1:0] arr_last;
    logic [CNT_W-1:0] cnt_inc;
    logic             terminal;
    logic             load_ok;
    logic             req_is_one;
    logic             pwm_level;

    // Decode helpers; arr_last is only meaningful while arr_sh != 0,
    // the guard keeps it from wrapping when idle.
    always_comb begin
        arr_last   = (arr_sh != '0) ? (arr_sh - ONE) : '0;
        cnt_inc    = cnt + ONE;
        terminal   = (state == RUN) && (cnt == arr_last);
        load_ok    = bus.cnt_en && (bus.counter_arr != '0);
        req_is_one = (bus.counter_arr == ONE);
        pwm_level  = (state == RUN) && (cnt < ccr_sh);
    end

    // Period FSM with shadow latching at boundaries; every output is a
    // register so the buzzer pin never sees combinational glitches.
    // period_tick is pre-decoded from the next counter value so it is high
    // in the same cycle that cnt holds arr_sh - 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            arr_sh   <= '0;
            ccr_sh   <= '0;
            pwm_q    <= 1'b0;
            tick_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            // one-cycle lag behind cnt; a final RUN value is flushed to 0
            // on the edge after the block drops to IDLE
            pwm_q <= pwm_level;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (load_ok) begin
                        state    <= RUN;
                        arr_sh   <= bus.counter_arr;
                        ccr_sh   <= bus.counter_ccr;
                        tick_q   <= req_is_one;
                        active_q <= 1'b1;
                    end else begin
                        tick_q   <= 1'b0;
                        active_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (terminal) begin
                        cnt <= '0;
                        if (load_ok) begin
                            arr_sh   <= bus.counter_arr;
                            ccr_sh   <= bus.counter_ccr;
                            tick_q   <= req_is_one;
                            active_q <= 1'b1;
                        end else begin
                            // rest note or disable: period done, go silent
                            state    <= IDLE;
                            arr_sh   <= '0;
                            ccr_sh   <= '0;
                            tick_q   <= 1'b0;
                            active_q <= 1'b0;
                        end
                    end else begin
                        // mid-period: inputs ignored, latched values rule
                        cnt      <= cnt_inc;
                        tick_q   <= (cnt_inc == arr_last);
                        active_q <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    arr_sh   <= '0;
                    ccr_sh   <= '0;
                    tick_q   <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_pwm       = pwm_q;
    assign bus.period_tick = tick_q;
    assign bus.active      = active_q;
endmodule
